// File: rtl/i2c_cfg_pkg.sv
// Shared types and helpers for the I2C configuration sequencer: FSM state
// encoding, LUT entry field positions and microsecond-to-cycle conversion.
package i2c_cfg_pkg;

    typedef enum logic [2:0] {
        PWR_WAIT,
        FETCH,
        ISSUE,
        WAIT,
        DELAY,
        NEXT,
        DONE,
        ERROR
    } cfg_state_e;

    // LUT entry layout: {dev, reg, data}
    localparam int DEV_MSB  = 23;
    localparam int DEV_LSB  = 16;
    localparam int REG_MSB  = 15;
    localparam int REG_LSB  = 8;
    localparam int DATA_MSB = 7;
    localparam int DATA_LSB = 0;

    function automatic longint us_to_cycles(input longint us, input longint clk_freq);
        return (us * clk_freq) / 64'd1_000_000;
    endfunction

endpackage

// File: rtl/cfg_delay_timer.sv
// Down-counter shared by the power-up wait and inline delay entries.
// 'expired' is high during the final counted cycle, or at once for a zero load.
module cfg_delay_timer #(
    parameter int               CNT_W   = 8,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             tick,
    output logic             expired
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (tick && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q <= CNT_W'(1));

endmodule

// File: rtl/i2c_cfg_sequencer.sv
// Walks a paged {dev, reg, data} LUT and issues each entry as one I2C write,
// with power-up/inline delays, NACK retries and EDID checksum substitution.
module i2c_cfg_sequencer
    import i2c_cfg_pkg::*;
#(
    parameter int         IDX_W         = 9,
    parameter int         PAGE_W        = 2,
    parameter int         CLK_FREQ      = 50_000_000,
    parameter int         PWRUP_US      = 1000,
    parameter int         DELAY_UNIT_US = 1000,
    parameter logic [7:0] DELAY_DEV     = 8'hFF,
    parameter int         MAX_RETRY     = 3,
    parameter logic [7:0] EDID_DEV      = 8'h6C,
    parameter bit         CSUM_AUTO     = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_start,
    input  logic [PAGE_W-1:0] cfg_page,
    output logic [PAGE_W-1:0] lut_page,
    output logic [IDX_W-1:0]  lut_index,
    input  logic [23:0]       lut_data,
    input  logic [IDX_W-1:0]  lut_size,
    output logic              i2c_req,
    output logic [7:0]        i2c_dev,
    output logic [7:0]        i2c_reg,
    output logic [7:0]        i2c_wdata,
    input  logic              i2c_done,
    input  logic              i2c_nack,
    output logic              cfg_busy,
    output logic              cfg_done,
    output logic              cfg_err,
    output logic [IDX_W-1:0]  err_index
);

    localparam longint PWRUP_CYC = us_to_cycles(PWRUP_US, CLK_FREQ);
    localparam longint UNIT_CYC  = us_to_cycles(DELAY_UNIT_US, CLK_FREQ);
    localparam longint MAX_CYC   = (255 * UNIT_CYC > PWRUP_CYC) ? 255 * UNIT_CYC : PWRUP_CYC;
    localparam int     CNT_W     = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC + 1);
    localparam int     RETRY_W   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0] PWRUP_VAL = CNT_W'(PWRUP_CYC);
    localparam logic [CNT_W-1:0] UNIT_VAL  = CNT_W'(UNIT_CYC);

    cfg_state_e          state_q, state_d;
    logic [PAGE_W-1:0]   page_q, page_d;
    logic [IDX_W-1:0]    index_q, index_d;
    logic [23:0]         entry_q, entry_d;
    logic [RETRY_W-1:0]  retry_q, retry_d;
    logic [7:0]          csum_q, csum_d;
    logic [7:0]          dev_q, dev_d;
    logic [7:0]          reg_q, reg_d;
    logic [7:0]          wdata_q, wdata_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [IDX_W-1:0]    err_index_q, err_index_d;
    logic                busy_q, busy_d;

    logic                tmr_load;
    logic [CNT_W-1:0]    tmr_val;
    logic                tmr_tick;
    logic                tmr_expired;

    logic                entry_is_edid;
    logic                entry_is_csum_slot;

    cfg_delay_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (PWRUP_VAL)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tick     (tmr_tick),
        .expired  (tmr_expired)
    );

    assign entry_is_edid      = (entry_q[DEV_MSB:DEV_LSB] == EDID_DEV);
    assign entry_is_csum_slot = entry_is_edid && (entry_q[REG_MSB-1:REG_LSB] == 7'h7F);

    always_comb begin
        state_d     = state_q;
        page_d      = page_q;
        index_d     = index_q;
        entry_d     = entry_q;
        retry_d     = retry_q;
        csum_d      = csum_q;
        dev_d       = dev_q;
        reg_d       = reg_q;
        wdata_d     = wdata_q;
        done_d      = done_q;
        err_d       = err_q;
        err_index_d = err_index_q;
        tmr_load    = 1'b0;
        tmr_val     = PWRUP_VAL;
        tmr_tick    = 1'b0;

        if (cfg_start) begin
            // Restart wins over everything, including an outstanding transaction.
            state_d  = PWR_WAIT;
            page_d   = cfg_page;
            index_d  = '0;
            retry_d  = '0;
            csum_d   = '0;
            done_d   = 1'b0;
            err_d    = 1'b0;
            tmr_load = 1'b1;
        end else begin
            case (state_q)
                PWR_WAIT: begin
                    tmr_tick = 1'b1;
                    if (tmr_expired) begin
                        state_d = FETCH;
                        index_d = '0;
                    end
                end
                FETCH: begin
                    if (index_q == lut_size) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        entry_d = lut_data;
                        if (lut_data[DEV_MSB:DEV_LSB] == DELAY_DEV) begin
                            state_d  = DELAY;
                            tmr_load = 1'b1;
                            tmr_val  = CNT_W'(lut_data[DATA_MSB:DATA_LSB]) * UNIT_VAL;
                        end else begin
                            state_d = ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    dev_d   = entry_q[DEV_MSB:DEV_LSB];
                    reg_d   = entry_q[REG_MSB:REG_LSB];
                    wdata_d = (CSUM_AUTO && entry_is_csum_slot) ? (8'd0 - csum_q)
                                                                : entry_q[DATA_MSB:DATA_LSB];
                    state_d = WAIT;
                end
                WAIT: begin
                    if (i2c_done) begin
                        if (!i2c_nack) begin
                            state_d = NEXT;
                            // Only ACKed writes touch the checksum, so retries never double-count.
                            if (entry_is_csum_slot) begin
                                csum_d = '0;
                            end else if (entry_is_edid) begin
                                csum_d = csum_q + entry_q[DATA_MSB:DATA_LSB];
                            end
                        end else if (retry_q < RETRY_W'(MAX_RETRY)) begin
                            retry_d = retry_q + RETRY_W'(1);
                            state_d = ISSUE;
                        end else begin
                            state_d     = ERROR;
                            err_d       = 1'b1;
                            err_index_d = index_q;
                        end
                    end
                end
                DELAY: begin
                    tmr_tick = 1'b1;
                    if (tmr_expired) begin
                        state_d = NEXT;
                    end
                end
                NEXT: begin
                    index_d = index_q + IDX_W'(1);
                    retry_d = '0;
                    state_d = FETCH;
                end
                DONE: begin
                    state_d = DONE;
                end
                ERROR: begin
                    state_d = ERROR;
                end
                default: begin
                    state_d = PWR_WAIT;
                end
            endcase
        end

        busy_d = (state_d != DONE) && (state_d != ERROR);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= PWR_WAIT;
            page_q      <= '0;
            index_q     <= '0;
            entry_q     <= '0;
            retry_q     <= '0;
            csum_q      <= '0;
            dev_q       <= '0;
            reg_q       <= '0;
            wdata_q     <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_index_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            page_q      <= page_d;
            index_q     <= index_d;
            entry_q     <= entry_d;
            retry_q     <= retry_d;
            csum_q      <= csum_d;
            dev_q       <= dev_d;
            reg_q       <= reg_d;
            wdata_q     <= wdata_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_index_q <= err_index_d;
            busy_q      <= busy_d;
        end
    end

    assign lut_page  = page_q;
    assign lut_index = index_q;
    assign i2c_req   = (state_q == WAIT);
    assign i2c_dev   = dev_q;
    assign i2c_reg   = reg_q;
    assign i2c_wdata = wdata_q;
    assign cfg_busy  = busy_q;
    assign cfg_done  = done_q;
    assign cfg_err   = err_q;
    assign err_index = err_index_q;

endmodule
